disp_scheduler: RTL and testbench
=================================

# disp_scheduler

Sequencing controller for the six-digit seven-segment bank. Accepts a binary value through a ready/load handshake and converts it to six BCD digits with an iterative shift-add-3 engine (one bit per clock). It then commits the digits atomically and drives six sevenSegDigit decoders with per-digit enables for leading-zero blanking, global on/off and optional blinking. Sits between the application datapath and the board HEX outputs.

## Interface
- WIDTH, 20: binary input width; must satisfy 2^WIDTH > 999999.
- NDIG, 6: digit count; fixed at 6 in this revision.
- BLINK_HALF, 25_000_000: blink half-period in clocks; 0.5 s at 50 MHz.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- value_in  in  WIDTH  binary value to display; sampled on an accepted load.
- load_in  in  1  load request; accepted only when ready_out=1.
- ready_out  out  1  idle, can accept a load.
- update_out  out  1  one-cycle pulse when new digits are committed.
- overflow_out  out  1  last committed value was saturated.
- on_in  in  1  0 blanks all digits; conversion is unaffected.
- blink_in  in  1  requests blinking; ignored without DISP_BLINK_EN.
- hex_out  out  8*NDIG  active-low segments; digit k (0 = least significant) at [8k+7:8k].

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - ready_out=1.
  - On load_in=1: capture min(value_in, 999999) into the shift register.
  - Record overflow as (value_in > 999999).
  - Clear the 24-bit BCD scratch, set bit counter = WIDTH, go to CONVERT.
- CONVERT: per clock, add 3 to each scratch nibble that is ≥5, then shift {scratch, shift reg} left by 1 and decrement the counter. After the WIDTH-th shift, go to COMMIT.
- COMMIT:
  - Copy scratch into the digit registers.
  - Copy the overflow flag into overflow_out.
  - Pulse update_out, then return to IDLE.
- load_in while not IDLE is ignored. There is no queue and no error flag.
- Leading-zero blanking: digit k is enabled iff k=0 or some digit j≥k is nonzero. The value 0 displays a single "0".
- Per-digit decoder enable = blank-mask bit AND on_in AND NOT blink_phase_off.
- Digit registers feed sevenSegDigit instances combinationally. Digits never show a partial conversion.

## Timing
- Load accepted at edge 0: ready_out goes low after edge 0.
- Shifts occur on edges 1..WIDTH.
- Commit occurs on edge WIDTH+1. After that edge, digits and overflow_out are new, update_out=1 for exactly one cycle, and ready_out=1.
- Earliest next acceptance is edge WIDTH+2, so throughput is one load per WIDTH+2 clocks.
- on_in and blink_in act combinationally on hex_out, with zero cycles of latency.
- Reset values:
  - state IDLE, ready_out=1, update_out=0, overflow_out=0.
  - Digit registers 0, so hex_out shows digit0=8'hC0 (if on_in=1) and all other digits 8'hFF.
  - Blink counter 0, blink phase "on".
- Reset asserted mid-conversion aborts the conversion immediately. The prior digits are discarded, not retained.

## Configuration
- DISP_BLINK_EN defined:
  - A free-running counter counts 0..BLINK_HALF-1 and toggles blink_phase at wrap.
  - While blink_in=1 and the phase is "off", all digits are blanked.
  - The counter runs regardless of blink_in, so blink phase is not aligned to blink_in assertion.
- DISP_BLINK_EN undefined: no counter is instantiated, blink_in is unused, and behaviour is otherwise identical.

## Structure
- Shared package disp_pkg holds:
  - the state enum (IDLE, CONVERT, COMMIT);
  - DISP_MAX = 999999;
  - the BCD nibble typedef;
  - SEG_BLANK = 8'hFF.
- Natural sub-module: bin2bcd_iter, containing the shift register, scratch, counter and add-3 logic with start/done signals.
- The top level holds the FSM, digit registers, blank mask, blink logic and six sevenSegDigit instances.

## Test plan
- Reset with on_in=1 -> hex_out[7:0]=C0, other digits FF, ready_out=1, update_out=0.
- Load 123456 -> update_out pulses once, WIDTH+1 edges after acceptance; hex5..hex0 = F9,A4,B0,99,92,82; ready_out returns to 1.
- Load 42 -> hex1=99, hex0=A4, hex5..hex2=FF. Then load 0 -> hex0=C0, rest FF.
- Load 1000000 -> overflow_out=1 and all six digits = 98. A following load of 7 -> overflow_out=0, hex0=F8, rest FF.
- Load 5; assert load_in with 9 three cycles later -> second request ignored, result shows 92. Then start a load of 777 and assert rst_n=0 at shift 10 -> reset values, no update_out pulse.
- DISP_BLINK_EN, BLINK_HALF=4, value 8, blink_in=1 -> hex0 alternates 80 / FF every 4 cycles. on_in=0 -> all FF regardless of blink phase.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the six-digit seven-segment display scheduler.
package disp_pkg;
   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} disp_state_t;
   localparam int DISP_MAX = 999999;
   typedef logic [3:0] bcd_t;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative shift-add-3 binary to BCD converter, one input bit per clock.
module bin2bcd_iter
   import disp_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int NDIG  = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     value,
   output logic                 done,
   output bcd_t [NDIG-1:0]      bcd
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]  sr;
   logic [CW-1:0]     cnt;
   bcd_t [NDIG-1:0]   scratch;
   bcd_t [NDIG-1:0]   adj;
   logic [4*NDIG-1:0] adj_flat;

   always_comb begin
      adj = scratch;
      for (int i = 0; i < NDIG; i++) begin
         if (scratch[i] >= 4'd5) adj[i] = scratch[i] + 4'd3;
      end
      adj_flat = adj;
   end

   // done flags the cycle whose edge performs the final shift
   assign done = (cnt == CW'(1));
   assign bcd  = scratch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         cnt     <= '0;
         scratch <= '0;
      end else if (start) begin
         sr      <= value;
         cnt     <= CW'(WIDTH);
         scratch <= '0;
      end else if (cnt != '0) begin
         scratch <= {adj_flat[4*NDIG-2:0], sr[WIDTH-1]};
         sr      <= {sr[WIDTH-2:0], 1'b0};
         cnt     <= cnt - CW'(1);
      end
   end
endmodule

// File: rtl/sevenSegDigit.sv
// One BCD digit to active-low segments {dp,g,f,e,d,c,b,a}; blank when disabled.
module sevenSegDigit
   import disp_pkg::*;
(
   input  bcd_t       digit,
   input  logic       en,
   output logic [7:0] seg
);
   always_comb begin
      seg = SEG_BLANK;
      if (en) begin
         case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h98;
            default: seg = SEG_BLANK;
         endcase
      end
   end
endmodule

// File: rtl/disp_scheduler.sv
// Six-digit display scheduler: load handshake, BCD conversion, atomic commit, blanking.
// Optional blinking is compiled in with `define DISP_BLINK_EN.
module disp_scheduler
   import disp_pkg::*;
#(
   parameter int WIDTH      = 20,
   parameter int NDIG       = 6,
   parameter int BLINK_HALF = 25_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  value_in,
   input  logic              load_in,
   output logic              ready_out,
   output logic              update_out,
   output logic              overflow_out,
   input  logic              on_in,
   input  logic              blink_in,
   output logic [8*NDIG-1:0] hex_out,
   output disp_state_t       state_dbg
);
   // Handshake: a load transfers on any rising edge where load_in=1 and ready_out=1;
   // requests while ready_out=0 are dropped, not held.
   disp_state_t       state, state_nxt;
   bcd_t [NDIG-1:0]   digits;
   bcd_t [NDIG-1:0]   bcd;
   logic              start, done, ovf_pend, blink_off, seen;
   logic [WIDTH-1:0]  sat_value;
   logic [NDIG-1:0]   mask, dig_en;

   assign ready_out = (state == IDLE);
   assign state_dbg = state;
   assign start     = ready_out && load_in;
   assign sat_value = (value_in > WIDTH'(DISP_MAX)) ? WIDTH'(DISP_MAX) : value_in;

   bin2bcd_iter #(.WIDTH(WIDTH), .NDIG(NDIG)) u_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .value (sat_value),
      .done  (done),
      .bcd   (bcd)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_in) state_nxt = CONVERT;
         CONVERT: if (done)    state_nxt = COMMIT;
         COMMIT:               state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         digits       <= '0;
         ovf_pend     <= 1'b0;
         overflow_out <= 1'b0;
         update_out   <= 1'b0;
      end else begin
         state      <= state_nxt;
         update_out <= (state == COMMIT);
         if (start) ovf_pend <= (value_in > WIDTH'(DISP_MAX));
         if (state == COMMIT) begin
            digits       <= bcd;
            overflow_out <= ovf_pend;
         end
      end
   end

`ifdef DISP_BLINK_EN
   localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   logic [BW-1:0] blink_cnt;
   logic          phase_off;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         phase_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
         blink_cnt <= '0;
         phase_off <= ~phase_off;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end
   assign blink_off = blink_in && phase_off;
`else
   logic unused_blink;
   assign unused_blink = blink_in;
   assign blink_off    = 1'b0;
`endif

   // A digit shows if it is the units digit or anything at or above it is nonzero
   always_comb begin
      seen = 1'b0;
      mask = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         seen    = seen | (digits[k] != 4'd0);
         mask[k] = seen | (k == 0);
      end
      dig_en = mask & {NDIG{on_in && !blink_off}};
   end

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      sevenSegDigit u_seg (
         .digit (digits[g]),
         .en    (dig_en[g]),
         .seg   (hex_out[8*g +: 8])
      );
   end
endmodule

// File: tb/tb_disp_scheduler.sv
// Directed and randomized bench for disp_scheduler against a decimal-arithmetic display model.
module tb_disp_scheduler;
   import disp_pkg::*;

   localparam int WIDTH = 20;
   localparam int NDIG  = 6;
   localparam int BHALF = 4;
`ifdef DISP_BLINK_EN
   localparam bit BLINK_BUILD = 1'b1;
`else
   localparam bit BLINK_BUILD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [WIDTH-1:0]  value_in = '0;
   logic              load_in = 1'b0;
   logic              ready_out, update_out, overflow_out;
   logic              on_in = 1'b1;
   logic              blink_in = 1'b0;
   logic [8*NDIG-1:0] hex_out;
   disp_state_t       state_dbg;

   int n_checks = 0;
   int n_fails  = 0;
   int upd_cnt  = 0;
   int edge_cnt = 0;
   int cur_val  = 0;

   logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

   disp_scheduler #(.WIDTH(WIDTH), .NDIG(NDIG), .BLINK_HALF(BHALF)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .value_in     (value_in),
      .load_in      (load_in),
      .ready_out    (ready_out),
      .update_out   (update_out),
      .overflow_out (overflow_out),
      .on_in        (on_in),
      .blink_in     (blink_in),
      .hex_out      (hex_out),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   always @(posedge clk) begin
      #1;
      if (update_out === 1'b1) upd_cnt++;
   end

   // Display model: saturate, split into decimal digits, blank leading zeros.
   function automatic logic [47:0] exp_hex(input int v, input bit on, input bit boff);
      int sat, top, p;
      int d [NDIG];
      logic [47:0] r;
      sat = (v > DISP_MAX) ? DISP_MAX : v;
      top = 0;
      p = 1;
      for (int k = 0; k < NDIG; k++) begin
         d[k] = (sat / p) % 10;
         if (d[k] != 0) top = k;
         p = p * 10;
      end
      for (int k = 0; k < NDIG; k++)
         r[8*k +: 8] = (k <= top && on && !boff) ? seg_tbl[d[k]] : 8'hFF;
      return r;
   endfunction

   function automatic bit exp_boff();
      return BLINK_BUILD && blink_in && (((edge_cnt / BHALF) % 2) == 1);
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_load(input int v);
      int n;
      n = 0;
      @(negedge clk);
      while (ready_out !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_load", 48'(ready_out), 48'd1);
      value_in = WIDTH'(v);
      load_in  = 1'b1;
      @(negedge clk);
      load_in  = 1'b0;
      chk("ready_low_busy", 48'(ready_out), 48'd0);
   endtask

   task automatic wait_update(output int n);
      n = 0;
      while (update_out !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("update_seen", 48'(update_out), 48'd1);
   endtask

   task automatic check_result(input string tag, input int v);
      chk({tag, "_hex"}, hex_out, exp_hex(v, on_in, exp_boff()));
      chk({tag, "_ovf"}, 48'(overflow_out), 48'(v > DISP_MAX));
      chk({tag, "_ready"}, 48'(ready_out), 48'd1);
      @(negedge clk);
      chk({tag, "_upd_one_cycle"}, 48'(update_out), 48'd0);
   endtask

   task automatic full_load(input string tag, input int v);
      int n;
      start_load(v);
      wait_update(n);
      chk({tag, "_latency"}, 48'(n), 48'(WIDTH + 1));
      cur_val = v;
      check_result(tag, v);
   endtask

   initial begin
      int n, v, u0;
      repeat (3) @(negedge clk);
      chk("reset_ready", 48'(ready_out), 48'd1);
      chk("reset_update", 48'(update_out), 48'd0);
      chk("reset_hex_in", hex_out, 48'hFFFF_FFFF_FFC0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_hex", hex_out, 48'hFFFF_FFFF_FFC0);
      chk("reset_ovf", 48'(overflow_out), 48'd0);

      full_load("v123456", 123456);
      chk("v123456_const", hex_out, 48'hF9A4_B099_9282);
      full_load("v42", 42);
      chk("v42_const", hex_out, 48'hFFFF_FFFF_99A4);
      full_load("v0", 0);
      full_load("v1000000", 1000000);
      chk("v1000000_const", hex_out, 48'h9898_9898_9898);
      full_load("v7", 7);
      full_load("v999999", 999999);
      full_load("v100000", 100000);

      // second load while busy must be dropped
      start_load(5);
      repeat (2) @(negedge clk);
      value_in = WIDTH'(9);
      load_in  = 1'b1;
      chk("busy_ready_low", 48'(ready_out), 48'd0);
      @(negedge clk);
      load_in = 1'b0;
      wait_update(n);
      cur_val = 5;
      check_result("ignored_load", 5);
      repeat (3) @(negedge clk);
      chk("no_second_update", 48'(update_out), 48'd0);
      chk("still_ready", 48'(ready_out), 48'd1);

      // reset in the middle of a conversion
      u0 = upd_cnt;
      start_load(777);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 48'(ready_out), 48'd1);
      chk("midrst_update", 48'(update_out), 48'd0);
      chk("midrst_hex", hex_out, 48'hFFFF_FFFF_FFC0);
      chk("midrst_ovf", 48'(overflow_out), 48'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cur_val = 0;
      repeat (WIDTH + 4) @(negedge clk);
      chk("midrst_no_pulse", 48'(upd_cnt - u0), 48'd0);
      chk("midrst_hex_after", hex_out, exp_hex(0, 1'b1, 1'b0));

      // randomized loads with on_in toggling
      for (int i = 0; i < 16; i++) begin
         case ($urandom_range(0, 3))
            0: v = $urandom_range(0, 99);
            1: v = $urandom_range(0, DISP_MAX);
            2: v = $urandom_range(0, (1 << WIDTH) - 1);
            default: v = DISP_MAX + $urandom_range(0, 1);
         endcase
         full_load($sformatf("rnd%0d", i), v);
         on_in = 1'b0;
         #1;
         chk($sformatf("rnd%0d_off", i), hex_out, 48'hFFFF_FFFF_FFFF);
         on_in = 1'b1;
         #1;
         chk($sformatf("rnd%0d_on", i), hex_out, exp_hex(v, 1'b1, 1'b0));
      end

      // blinking (inert unless the blink feature is compiled in)
      full_load("v8", 8);
      blink_in = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("blink%0d", c), hex_out, exp_hex(8, 1'b1, exp_boff()));
      end
      on_in = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("blink_off%0d", c), hex_out, 48'hFFFF_FFFF_FFFF);
      end
      on_in    = 1'b1;
      blink_in = 1'b0;
      @(negedge clk);
      chk("blink_release", hex_out, exp_hex(cur_val, 1'b1, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #2_000_000;
      n_fails++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
